// File: rtl/serial_in_parallel_out_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_in_parallel_out_pkg
// Description : Shared state encoding and width helpers for the serial-in /
//               parallel-out receive shift register.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_in_parallel_out_pkg;

    // Collector states: waiting, accumulating bits, holding a completed word
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int C_DEFAULT_WORD_LENGTH = 4;

    // Collected word is the product width of two operands
    function automatic int out_length(input int word_length);
        return 2 * word_length;
    endfunction

    // Counter must be able to represent the value OUT_LENGTH itself
    function automatic int count_width(input int word_length);
        return $clog2(2 * word_length + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_in_parallel_out_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : serial_in_parallel_out_bit_counter
// Description : Saturating bit counter with synchronous clear and enable.
//               Flags when the next accepted bit completes the word.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_in_parallel_out_bit_counter #(
    parameter int MAX_COUNT   = 8,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   i_clr,
    input  logic                   i_en,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_last_bit
);

    localparam logic [COUNT_WIDTH-1:0] C_MAX      = COUNT_WIDTH'(MAX_COUNT);
    localparam logic [COUNT_WIDTH-1:0] C_MAX_LESS = COUNT_WIDTH'(MAX_COUNT - 1);

    logic [COUNT_WIDTH-1:0] r_count;
    logic                   w_full;

    assign w_full     = (r_count == C_MAX);
    assign o_last_bit = (r_count == C_MAX_LESS);
    assign o_count    = r_count;

    // Count accepted bits; clear dominates, saturate at MAX_COUNT (no wrap)
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !w_full) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_in_parallel_out.sv
`default_nettype none
// ============================================================================
// Module      : serial_in_parallel_out
// Description : Collects an LSB-first serial stream into a 2*WORD_LENGTH-bit
//               word, pulses valid on completion and holds the word.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_in_parallel_out
    import serial_in_parallel_out_pkg::*;
#(
    parameter  int WORD_LENGTH = C_DEFAULT_WORD_LENGTH,
    localparam int OUT_LENGTH  = out_length(WORD_LENGTH),
    localparam int COUNT_WIDTH = count_width(WORD_LENGTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   data_in,
    input  logic                   shift,
    output logic [OUT_LENGTH-1:0]  data_out,
    output logic                   valid,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] bit_count,
    output logic                   overrun
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [OUT_LENGTH-1:0]   r_shift_reg;
    logic [OUT_LENGTH-1:0]   r_data_out;
    logic                    r_valid;
    logic                    r_overrun;
    logic [OUT_LENGTH-1:0]   w_shifted;
    logic                    w_accept;
    logic                    w_complete;
    logic                    w_last_bit;
    logic                    w_cnt_clr;

    // start always wins over shift, so a start-cycle bit is never accepted
    assign w_accept   = shift && !start && (r_state == COLLECT);
    assign w_complete = w_accept && w_last_bit;
    assign w_shifted  = {data_in, r_shift_reg[OUT_LENGTH-1:1]};
    assign w_cnt_clr  = !reset || start;

    serial_in_parallel_out_bit_counter #(
        .MAX_COUNT   (OUT_LENGTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_bit_counter (
        .clk        (clk),
        .i_clr      (w_cnt_clr),
        .i_en       (w_accept),
        .o_count    (bit_count),
        .o_last_bit (w_last_bit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: start restarts collection from any state, final bit ends it
    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = COLLECT;
        end else if (w_complete) begin
            w_state_next = DONE;
        end
    end

    // Datapath: shift register, held output word, valid pulse, sticky overrun
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift_reg <= '0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_valid <= w_complete;
            if (start) begin
                r_shift_reg <= '0;
            end else if (w_accept) begin
                r_shift_reg <= w_shifted;
            end
            if (w_complete) begin
                r_data_out <= w_shifted;
            end
            if (start) begin
                r_overrun <= 1'b0;
            end else if (shift && (r_state != COLLECT)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign data_out = r_data_out;
    assign valid    = r_valid;
    assign overrun  = r_overrun;
    assign busy     = (r_state == COLLECT);

endmodule
`default_nettype wire

// File: tb/tb_serial_in_parallel_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_in_parallel_out
// Description : Self-checking bench for serial_in_parallel_out against a
//               behavioural word-accumulation model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_in_parallel_out;

    localparam int WL  = 4;
    localparam int OL  = 2 * WL;
    localparam int CW  = $clog2(OL + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          data_in = 1'b0;
    logic          shift = 1'b0;
    logic [OL-1:0] data_out;
    logic          valid;
    logic          busy;
    logic [CW-1:0] bit_count;
    logic          overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 idle, 1 collecting, 2 holding a finished word
    int            m_mode  = 0;
    logic [OL-1:0] m_word  = '0;
    logic [CW-1:0] m_cnt   = '0;
    logic [OL-1:0] m_out   = '0;
    logic          m_valid = 1'b0;
    logic          m_ovr   = 1'b0;

    serial_in_parallel_out #(.WORD_LENGTH(WL)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .data_in   (data_in),
        .shift     (shift),
        .data_out  (data_out),
        .valid     (valid),
        .busy      (busy),
        .bit_count (bit_count),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs, advance the model at the edge, settle
    task automatic step(input logic st, input logic sh, input logic din);
        start   = st;
        shift   = sh;
        data_in = din;
        @(posedge clk);
        m_valid = 1'b0;
        if (!reset) begin
            m_mode = 0; m_word = '0; m_cnt = '0; m_out = '0; m_ovr = 1'b0;
        end else if (st) begin
            m_mode = 1; m_word = '0; m_cnt = '0; m_ovr = 1'b0;
        end else if (sh) begin
            if (m_mode == 1) begin
                m_word[m_cnt] = din;
                m_cnt = m_cnt + 1'b1;
                if (int'(m_cnt) == OL) begin
                    m_out   = m_word;
                    m_valid = 1'b1;
                    m_mode  = 2;
                end
            end else begin
                m_ovr = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(0, 0, 0);
        step(0, 1, 1);
        n_tests++;
        if ({data_out, valid, busy, bit_count, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got do=%h v=%b b=%b cnt=%0d ovr=%b, expected all zero",
                     data_out, valid, busy, bit_count, overrun);
        end
        reset = 1'b1;
    endtask

    task automatic test_a5();
        logic [7:0] pat;
        pat = 8'hA5;
        step(1, 0, 0);
        n_tests++;
        if (busy !== 1'b1 || bit_count !== '0) begin
            n_fail++;
            $display("FAIL a5_start: busy=%b cnt=%0d, expected busy=1 cnt=0", busy, bit_count);
        end
        for (int i = 0; i < OL; i++) begin
            step(0, 1, pat[i]);
            n_tests++;
            if (valid !== m_valid || bit_count !== m_cnt) begin
                n_fail++;
                $display("FAIL a5_shift%0d: valid=%b cnt=%0d, expected valid=%b cnt=%0d",
                         i, valid, bit_count, m_valid, m_cnt);
            end
        end
        n_tests++;
        if (data_out !== 8'hA5 || valid !== 1'b1 || int'(bit_count) != OL || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL a5_done: do=%h v=%b cnt=%0d busy=%b, expected A5 1 8 0",
                     data_out, valid, bit_count, busy);
        end
        step(0, 0, 0);
        n_tests++;
        if (valid !== 1'b0 || data_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL a5_pulse_width: v=%b do=%h, expected 0 A5", valid, data_out);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] pat;
        int pulses;
        pat = 8'hA5;
        pulses = 0;
        step(1, 0, 0);
        for (int i = 0; i < OL; i++) begin
            for (int g = $urandom_range(3, 0); g > 0; g--) begin
                step(0, 0, 1'($urandom));
                if (valid) pulses++;
                n_tests++;
                if (bit_count !== m_cnt || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gaps_hold: cnt=%0d busy=%b, expected cnt=%0d busy=1",
                             bit_count, busy, m_cnt);
                end
            end
            step(0, 1, pat[i]);
            if (valid) pulses++;
        end
        step(0, 0, 0);
        if (valid) pulses++;
        n_tests++;
        if (data_out !== 8'hA5 || pulses != 1) begin
            n_fail++;
            $display("FAIL gaps_result: do=%h pulses=%0d, expected A5 1", data_out, pulses);
        end
    endtask

    task automatic test_abort();
        logic [7:0] pat;
        pat = 8'h3C;
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1'($urandom));
            n_tests++;
            if (valid !== 1'b0 || data_out !== 8'hA5) begin
                n_fail++;
                $display("FAIL abort_partial: v=%b do=%h, expected 0 A5", valid, data_out);
            end
        end
        step(1, 0, 0);
        n_tests++;
        if (valid !== 1'b0 || bit_count !== '0 || data_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL abort_restart: v=%b cnt=%0d do=%h, expected 0 0 A5", valid, bit_count, data_out);
        end
        for (int i = 0; i < OL; i++) begin
            step(0, 1, pat[i]);
            n_tests++;
            if (i < OL - 1 && data_out !== 8'hA5) begin
                n_fail++;
                $display("FAIL abort_hold: do=%h, expected A5", data_out);
            end
        end
        n_tests++;
        if (data_out !== 8'h3C || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_3c: do=%h v=%b, expected 3C 1", data_out, valid);
        end
    endtask

    task automatic test_overrun();
        step(0, 1, 1);
        n_tests++;
        if (overrun !== 1'b1 || data_out !== 8'h3C || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_done: ovr=%b do=%h v=%b, expected 1 3C 0", overrun, data_out, valid);
        end
        step(1, 1, 1);
        n_tests++;
        if (overrun !== 1'b0 || bit_count !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_clear: ovr=%b cnt=%0d busy=%b, expected 0 0 1", overrun, bit_count, busy);
        end
    endtask

    task automatic test_start_shift();
        step(1, 1, 1);
        for (int i = 0; i < OL; i++) step(0, 1, 1'b0);
        n_tests++;
        if (data_out !== 8'h00 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL start_shift: do=%h v=%b, expected 00 1", data_out, valid);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 0);
        for (int i = 0; i < OL; i++) step(0, 1, 1'b1);
        n_tests++;
        if (data_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_mid_ff: do=%h, expected FF", data_out);
        end
        step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1'b1);
        reset = 1'b0;
        step(0, 0, 0);
        reset = 1'b1;
        n_tests++;
        if (data_out !== '0 || bit_count !== '0 || busy !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: do=%h cnt=%0d busy=%b v=%b, expected 0 0 0 0",
                     data_out, bit_count, busy, valid);
        end
        step(0, 1, 1);
        n_tests++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_ovr: ovr=%b busy=%b, expected 1 0", overrun, busy);
        end
    endtask

    task automatic test_random();
        logic prev_valid;
        prev_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(60, 0) != 0);
            step(($urandom_range(11, 0) == 0), 1'($urandom), 1'($urandom));
            n_tests++;
            if (data_out !== m_out || valid !== m_valid || busy !== (m_mode == 1) ||
                bit_count !== m_cnt || overrun !== m_ovr) begin
                n_fail++;
                $display("FAIL random_c%0d: do=%h v=%b b=%b cnt=%0d ovr=%b, expected %h %b %b %0d %b",
                         c, data_out, valid, busy, bit_count, overrun,
                         m_out, m_valid, (m_mode == 1), m_cnt, m_ovr);
            end
            n_tests++;
            if (prev_valid && valid) begin
                n_fail++;
                $display("FAIL random_valid_twice_c%0d: valid=1 on consecutive cycles, expected 0", c);
            end
            prev_valid = valid;
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_a5();
        test_gaps();
        test_abort();
        test_overrun();
        test_start_shift();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_in_parallel_out.md
Name: serial_in_parallel_out

Overview:
Receive-side counterpart of the multiplier's parallel-in/serial-out shift register. Collects a serial bit stream, LSB first, one bit per shift strobe, into a 2*WORD_LENGTH-bit parallel word, which is the product width. Signals completion with a one-cycle valid pulse and holds the word until the next one completes. Sits between the serial shift-and-add datapath and the parallel result register/display logic.

Parameters:
WORD_LENGTH, 4, operand width; collected word width is OUT_LENGTH = 2*WORD_LENGTH (localparam).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-low reset (sampled on rising edge of clk)
start  input  1  begin new word: clear shift register and bit counter, enter COLLECT
data_in  input  1  serial data bit, sampled when shift=1
shift  input  1  bit strobe; one bit accepted per cycle with shift=1 in COLLECT
data_out  output  OUT_LENGTH  last completed word, held stable between completions
valid  output  1  one-cycle pulse, the cycle data_out updates
busy  output  1  high while in COLLECT
bit_count  output  $clog2(OUT_LENGTH+1)  bits accepted in the current word
overrun  output  1  sticky: shift seen while not in COLLECT; cleared by start or reset

Behaviour:
- Reset (reset=0 at clk edge): state=IDLE, shift register=0, data_out=0, valid=0, busy=0, bit_count=0, overrun=0. Reset mid-word discards partial bits; data_out also clears.
- States: IDLE, COLLECT, DONE.
- IDLE: start=1 -> COLLECT next cycle, with shift register and bit_count cleared. shift=1 without start -> overrun<=1, bit dropped.
- COLLECT: shift=1 -> shift register <= {data_in, sr[OUT_LENGTH-1:1]} (insert at MSB, shift right), bit_count+1. After OUT_LENGTH bits, the first received bit sits in bit 0.
- Completion: the edge that accepts bit number OUT_LENGTH also loads data_out <= {data_in, sr[OUT_LENGTH-1:1]}, sets valid=1 for exactly that following cycle, and moves to DONE. bit_count then reads OUT_LENGTH.
- Latency: data_out/valid are visible the cycle after the final shift is sampled.
- Gaps (shift=0) in COLLECT are allowed indefinitely; state and count hold.
- DONE: data_out holds. shift=1 -> overrun<=1, bit ignored. start=1 -> COLLECT with count cleared.
- start has priority over shift in every state. On a start+shift cycle the bit is discarded and counting begins on the next shift.
- start during COLLECT aborts the partial word. data_out keeps the previous completed word, no valid pulse, count restarts at 0.
- start clears overrun in the same edge. overrun from a shift in the same cycle as start is not set.
- busy = (state==COLLECT). valid is never high for two consecutive cycles.
- bit_count never exceeds OUT_LENGTH; no wrap-around.

Decomposition:
- Shared package: state encoding enum (IDLE/COLLECT/DONE), localparam OUT_LENGTH = 2*WORD_LENGTH, and the count width function/constant $clog2(OUT_LENGTH+1).
- Optional sub-module: bit_counter (synchronous clear, enable, terminal-count flag at OUT_LENGTH). Shift register and FSM stay in the top.

Test Plan:
- Reset, start, then 8 consecutive shifts with bits 1,0,1,0,0,1,0,1 (0xA5 LSB first) -> valid pulses once the cycle after the 8th shift, data_out=8'hA5, bit_count=8, busy=0.
- Same 0xA5 stream with 0-3 idle cycles between shifts -> identical data_out=8'hA5 and a single valid pulse; bit_count holds across gaps.
- After 0xA5 completes, start, send 5 bits, start again, then 8 bits of 0x3C -> no valid for the aborted word, data_out stays 8'hA5 until the 0x3C completion, then 8'h3C.
- In DONE, assert shift with data_in=1 -> overrun=1, data_out unchanged. Next start -> overrun=0, bit_count=0, busy=1.
- start and shift both high with data_in=1, followed by 8 bits of 0x00 -> data_out=8'h00 (the start-cycle bit is discarded).
- reset=0 after 4 bits of a word following a completed 0xFF -> data_out=0, bit_count=0, state IDLE. Shifts without start then set overrun=1.
